// File: rtl/iopmp_pkg.sv
// iopmp_pkg: shared constants and FSM state encodings for the IOPMP check arbiter
package iopmp_pkg;
  localparam int DEF_SID_W = 3;
  localparam int DEF_ADDR_W = 32;
  localparam int NUM_LANES = 2;
  localparam logic [1:0] ST_RUN = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
endpackage

// File: rtl/iopmp_check_arbiter_if.sv
// iopmp_check_arbiter_if: requester, checker and quiesce signals of the check arbiter
interface iopmp_check_arbiter_if
  import iopmp_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SID_W = DEF_SID_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic [NUM_REQ-1:0] req_valid, req_ready, req_write, rsp_valid, rsp_deny;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*SID_W-1:0] req_sid;
  logic [SID_W-1:0] chk_source_id;
  logic chk_addr0_valid, chk_addr1_valid, chk_addr0_write, chk_addr1_write;
  logic [ADDR_W-1:0] chk_addr0, chk_addr1;
  logic chk_addr0_deny, chk_addr1_deny;
  logic cfg_req, cfg_ack;
  modport slave (
    input req_valid, req_addr, req_write, req_sid, chk_addr0_deny, chk_addr1_deny, cfg_req,
    output req_ready, rsp_valid, rsp_deny, chk_source_id, chk_addr0_valid, chk_addr1_valid,
    output chk_addr0, chk_addr1, chk_addr0_write, chk_addr1_write, cfg_ack
  );
  modport master (
    output req_valid, req_addr, req_write, req_sid, chk_addr0_deny, chk_addr1_deny, cfg_req,
    input req_ready, rsp_valid, rsp_deny, chk_source_id, chk_addr0_valid, chk_addr1_valid,
    input chk_addr0, chk_addr1, chk_addr0_write, chk_addr1_write, cfg_ack
  );
endinterface

// File: rtl/iopmp_check_arbiter_rr_pick.sv
// iopmp_rr_pick: first set mask bit at or after ptr, wrapping modulo N
module iopmp_rr_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  onehot
);
  logic [IW-1:0] j;
  always_comb begin
    found = 1'b0;
    idx = '0;
    onehot = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (mask[j]) begin
        found = 1'b1;
        idx = j;
      end
    end
    onehot[idx] = found;
  end
endmodule

// File: rtl/iopmp_check_arbiter.sv
// iopmp_check_arbiter: shares two IOPMP check lanes among requesters, returns deny two cycles later
module iopmp_check_arbiter
  import iopmp_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SID_W = DEF_SID_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic clk,
  input logic rst,
  iopmp_check_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  function automatic logic [IW-1:0] inc(input logic [IW-1:0] i);
    return (i == IW'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction
  logic [1:0] state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, idx0, idx1;
  logic found0, found1, grant_en, g0, g1, drained;
  logic [NUM_REQ-1:0] oh0, oh1, sid_match;
  logic [SID_W-1:0] sid_a [NUM_REQ];
  logic [ADDR_W-1:0] addr_a [NUM_REQ];
  logic s1_v0_q, s1_v0_d, s1_v1_q, s1_v1_d, s1_w0_q, s1_w0_d, s1_w1_q, s1_w1_d;
  logic [ADDR_W-1:0] s1_a0_q, s1_a0_d, s1_a1_q, s1_a1_d;
  logic [SID_W-1:0] s1_sid_q, s1_sid_d;
  logic [IW-1:0] s1_o0_q, s1_o0_d, s1_o1_q, s1_o1_d, s2_o0_q, s2_o0_d, s2_o1_q, s2_o1_d;
  logic s2_v0_q, s2_v0_d, s2_v1_q, s2_v1_d, s2_d0_q, s2_d0_d, s2_d1_q, s2_d1_d;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign sid_a[i] = bus.req_sid[i*SID_W +: SID_W];
    assign addr_a[i] = bus.req_addr[i*ADDR_W +: ADDR_W];
    assign sid_match[i] = sid_a[i] == sid_a[idx0];
  end
  iopmp_rr_pick #(.N(NUM_REQ)) u_pick0 (
    .mask(bus.req_valid), .ptr(rr_ptr_q), .found(found0), .idx(idx0), .onehot(oh0)
  );
  // Lane 1 may only carry a requester sharing lane 0's sid: the checker has one source_ID input
  iopmp_rr_pick #(.N(NUM_REQ)) u_pick1 (
    .mask(bus.req_valid & sid_match & ~oh0), .ptr(inc(idx0)), .found(found1), .idx(idx1),
    .onehot(oh1)
  );
  always_comb begin
    grant_en = state_q == ST_RUN && !bus.cfg_req && !rst;
    g0 = grant_en && found0;
    g1 = g0 && found1;
    bus.req_ready = (g0 ? oh0 : '0) | (g1 ? oh1 : '0);
    rr_ptr_d = g1 ? inc(idx1) : g0 ? inc(idx0) : rr_ptr_q;
    s1_v0_d = g0;
    s1_v1_d = g1;
    s1_a0_d = g0 ? addr_a[idx0] : '0;
    s1_a1_d = g1 ? addr_a[idx1] : '0;
    s1_w0_d = g0 && bus.req_write[idx0];
    s1_w1_d = g1 && bus.req_write[idx1];
    s1_sid_d = g0 ? sid_a[idx0] : '0;
    s1_o0_d = g0 ? idx0 : '0;
    s1_o1_d = g1 ? idx1 : '0;
    s2_v0_d = s1_v0_q;
    s2_v1_d = s1_v1_q;
    s2_d0_d = s1_v0_q && bus.chk_addr0_deny;
    s2_d1_d = s1_v1_q && bus.chk_addr1_deny;
    s2_o0_d = s1_o0_q;
    s2_o1_d = s1_o1_q;
    // No grant this cycle, so an empty S1 means both stages are empty next cycle
    drained = !s1_v0_q;
    state_d = state_q == ST_RUN ? (bus.cfg_req ? (drained ? ST_HOLD : ST_DRAIN) : ST_RUN)
            : state_q == ST_DRAIN ? (drained ? (bus.cfg_req ? ST_HOLD : ST_RUN) : ST_DRAIN)
            : (bus.cfg_req ? ST_HOLD : ST_RUN);
  end
  always_comb begin
    bus.rsp_valid = '0;
    bus.rsp_deny = '0;
    if (s2_v0_q) begin
      bus.rsp_valid[s2_o0_q] = 1'b1;
      bus.rsp_deny[s2_o0_q] = s2_d0_q;
    end
    if (s2_v1_q) begin
      bus.rsp_valid[s2_o1_q] = 1'b1;
      bus.rsp_deny[s2_o1_q] = s2_d1_q;
    end
  end
  assign bus.chk_source_id = s1_sid_q;
  assign bus.chk_addr0_valid = s1_v0_q;
  assign bus.chk_addr1_valid = s1_v1_q;
  assign bus.chk_addr0 = s1_a0_q;
  assign bus.chk_addr1 = s1_a1_q;
  assign bus.chk_addr0_write = s1_w0_q;
  assign bus.chk_addr1_write = s1_w1_q;
  assign bus.cfg_ack = state_q == ST_HOLD;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      rr_ptr_q <= '0;
      {s1_v0_q, s1_v1_q, s1_w0_q, s1_w1_q, s1_a0_q, s1_a1_q, s1_sid_q, s1_o0_q, s1_o1_q} <= '0;
      {s2_v0_q, s2_v1_q, s2_d0_q, s2_d1_q, s2_o0_q, s2_o1_q} <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      {s1_v0_q, s1_v1_q, s1_w0_q, s1_w1_q} <= {s1_v0_d, s1_v1_d, s1_w0_d, s1_w1_d};
      {s1_a0_q, s1_a1_q, s1_sid_q, s1_o0_q, s1_o1_q} <= {s1_a0_d, s1_a1_d, s1_sid_d, s1_o0_d, s1_o1_d};
      {s2_v0_q, s2_v1_q, s2_d0_q, s2_d1_q, s2_o0_q, s2_o1_q} <=
        {s2_v0_d, s2_v1_d, s2_d0_d, s2_d1_d, s2_o0_d, s2_o1_d};
    end
  end
endmodule

// File: tb/tb_iopmp_check_arbiter.sv
// tb_iopmp_check_arbiter: directed checks of grant, pipeline, quiesce and reset behaviour
module tb_iopmp_check_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int passed = 0;
  logic [31:0] fair_addr [4] = '{32'h8000_0000, 32'h10, 32'h8000_0020, 32'h30};
  iopmp_check_arbiter_if #(.NUM_REQ(4), .SID_W(3), .ADDR_W(32)) bus ();
  iopmp_check_arbiter #(.NUM_REQ(4), .SID_W(3), .ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // Checker model: denies any non-zero sid accessing the upper half of the address space
  assign bus.chk_addr0_deny = bus.chk_addr0_valid && bus.chk_source_id != 3'd0 && bus.chk_addr0[31];
  assign bus.chk_addr1_deny = bus.chk_addr1_valid && bus.chk_source_id != 3'd0 && bus.chk_addr1[31];
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic setreq(input int i, input logic v, input logic [2:0] sid, input logic [31:0] a,
                        input logic w);
    bus.req_valid[i] = v;
    bus.req_sid[i*3 +: 3] = sid;
    bus.req_addr[i*32 +: 32] = a;
    bus.req_write[i] = w;
  endtask
  task automatic clr;
    bus.req_valid = '0;
    bus.req_sid = '0;
    bus.req_addr = '0;
    bus.req_write = '0;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    clr();
    bus.cfg_req = 1'b0;
    tick();
    setreq(0, 1, 1, 32'h8000_0000, 1);
    #1 chk("rst_ready", bus.req_ready, 0);
    tick();
    clr();
    rst = 1'b0;
    #1;
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_deny", bus.rsp_deny, 0);
    chk("rst_chk0_valid", bus.chk_addr0_valid, 0);
    chk("rst_chk1_valid", bus.chk_addr1_valid, 0);
    chk("rst_chk_addr0", bus.chk_addr0, 0);
    chk("rst_sid", bus.chk_source_id, 0);
    chk("rst_cfg_ack", bus.cfg_ack, 0);
    chk("rst_rr_ptr", dut.rr_ptr_q, 0);
    setreq(0, 1, 1, 32'h8000_0000, 1);
    #1 chk("single_ready", bus.req_ready, 4'b0001);
    tick();
    clr();
    #1;
    chk("single_chk0_valid", bus.chk_addr0_valid, 1);
    chk("single_chk_addr0", bus.chk_addr0, 32'h8000_0000);
    chk("single_sid", bus.chk_source_id, 1);
    chk("single_write", bus.chk_addr0_write, 1);
    chk("single_chk1_valid", bus.chk_addr1_valid, 0);
    chk("single_rsp_early", bus.rsp_valid, 0);
    tick();
    #1;
    chk("single_rsp_valid", bus.rsp_valid, 4'b0001);
    chk("single_rsp_deny", bus.rsp_deny, 4'b0001);
    tick();
    #1 chk("single_rsp_once", bus.rsp_valid, 0);
    setreq(3, 1, 0, 32'h8000_0000, 0);
    #1 chk("sid0_ready", bus.req_ready, 4'b1000);
    tick();
    clr();
    tick();
    #1;
    chk("sid0_rsp_valid", bus.rsp_valid, 4'b1000);
    chk("sid0_rsp_deny", bus.rsp_deny, 0);
    chk("sid0_rr_ptr", dut.rr_ptr_q, 0);
    setreq(1, 1, 2, 32'h1000, 0);
    setreq(3, 1, 2, 32'h8000_1000, 1);
    #1 chk("dual_ready", bus.req_ready, 4'b1010);
    tick();
    clr();
    #1;
    chk("dual_addr0", bus.chk_addr0, 32'h1000);
    chk("dual_addr1", bus.chk_addr1, 32'h8000_1000);
    chk("dual_chk1_valid", bus.chk_addr1_valid, 1);
    chk("dual_sid", bus.chk_source_id, 2);
    chk("dual_write0", bus.chk_addr0_write, 0);
    chk("dual_write1", bus.chk_addr1_write, 1);
    chk("dual_rr_ptr", dut.rr_ptr_q, 0);
    tick();
    #1;
    chk("dual_rsp_valid", bus.rsp_valid, 4'b1010);
    chk("dual_rsp_deny", bus.rsp_deny, 4'b1000);
    tick();
    setreq(0, 1, 1, 32'h8000_0000, 0);
    setreq(1, 1, 2, 32'h100, 0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("mis_ready%0d", k), bus.req_ready, (k % 2 != 0) ? 4'b0010 : 4'b0001);
      chk($sformatf("mis_chk1_valid%0d", k), bus.chk_addr1_valid, 0);
      if (k > 0)
        chk($sformatf("mis_addr0_%0d", k), bus.chk_addr0, (k % 2 != 0) ? 32'h8000_0000 : 32'h100);
      if (k > 1) begin
        chk($sformatf("mis_rsp_valid%0d", k), bus.rsp_valid, (k % 2 != 0) ? 4'b0010 : 4'b0001);
        chk($sformatf("mis_rsp_deny%0d", k), bus.rsp_deny, (k % 2 != 0) ? 4'b0000 : 4'b0001);
      end
      tick();
    end
    clr();
    tick();
    tick();
    for (int c = 0; c < 6; c++) begin
      if (c < 4) for (int i = 0; i < 4; i++) setreq(i, 1, 1, fair_addr[i], 0);
      else clr();
      #1;
      chk($sformatf("fair_ready%0d", c), bus.req_ready,
          (c >= 4) ? 4'b0000 : (c % 2 == 0) ? 4'b1100 : 4'b0011);
      chk($sformatf("fair_rsp_valid%0d", c), bus.rsp_valid,
          (c < 2) ? 4'b0000 : (c % 2 == 0) ? 4'b1100 : 4'b0011);
      chk($sformatf("fair_rsp_deny%0d", c), bus.rsp_deny,
          (c < 2) ? 4'b0000 : (c % 2 == 0) ? 4'b0100 : 4'b0001);
      tick();
    end
    setreq(2, 1, 1, 32'h8000_0000, 0);
    setreq(3, 1, 1, 32'h40, 0);
    #1 chk("q_ready", bus.req_ready, 4'b1100);
    tick();
    clr();
    setreq(0, 1, 1, 32'h0, 0);
    bus.cfg_req = 1'b1;
    #1;
    chk("q1_ready", bus.req_ready, 0);
    chk("q1_chk0_valid", bus.chk_addr0_valid, 1);
    chk("q1_chk1_valid", bus.chk_addr1_valid, 1);
    chk("q1_ack", bus.cfg_ack, 0);
    tick();
    #1;
    chk("q2_ready", bus.req_ready, 0);
    chk("q2_rsp_valid", bus.rsp_valid, 4'b1100);
    chk("q2_rsp_deny", bus.rsp_deny, 4'b0100);
    chk("q2_ack", bus.cfg_ack, 0);
    tick();
    #1;
    chk("q3_ack", bus.cfg_ack, 1);
    chk("q3_rsp_valid", bus.rsp_valid, 0);
    chk("q3_ready", bus.req_ready, 0);
    chk("q3_chk0_valid", bus.chk_addr0_valid, 0);
    tick();
    bus.cfg_req = 1'b0;
    #1;
    chk("q4_ack", bus.cfg_ack, 1);
    chk("q4_ready", bus.req_ready, 0);
    tick();
    #1;
    chk("q5_ack", bus.cfg_ack, 0);
    chk("q5_ready", bus.req_ready, 4'b0001);
    tick();
    clr();
    #1 chk("q6_chk0_valid", bus.chk_addr0_valid, 1);
    tick();
    #1 chk("q7_rsp_valid", bus.rsp_valid, 4'b0001);
    tick();
    bus.cfg_req = 1'b1;
    #1 chk("e0_ack", bus.cfg_ack, 0);
    tick();
    #1 chk("e1_ack", bus.cfg_ack, 1);
    bus.cfg_req = 1'b0;
    tick();
    #1 chk("e2_ack", bus.cfg_ack, 0);
    tick();
    setreq(1, 1, 3, 32'h8000_0000, 1);
    #1 chk("r0_ready", bus.req_ready, 4'b0010);
    tick();
    clr();
    rst = 1'b1;
    #1 chk("r1_chk0_valid", bus.chk_addr0_valid, 1);
    tick();
    rst = 1'b0;
    #1;
    chk("r2_rsp_valid", bus.rsp_valid, 0);
    chk("r2_chk0_valid", bus.chk_addr0_valid, 0);
    chk("r2_chk_addr0", bus.chk_addr0, 0);
    chk("r2_sid", bus.chk_source_id, 0);
    chk("r2_rr_ptr", dut.rr_ptr_q, 0);
    chk("r2_ack", bus.cfg_ack, 0);
    tick();
    #1;
    chk("r3_rsp_valid", bus.rsp_valid, 0);
    chk("r3_rsp_deny", bus.rsp_deny, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
